seg7_scan_driver: RTL and testbench

//  N-digit time-multiplexed seven-segment driver. Successor to the fixed two-digit display mux.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and hex decode table for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t seg7_encode(
    input logic [3:0] nib
  );
    return SEG7_HEX[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to segment decode with a blank override.
// Blanked digits drive all segments off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  assign seg = blank ? '0 : seg7_encode(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment driver with prescaled scan,
// anti-ghost blanking and tear-free load; SEG7_DP_EN adds decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1024,
  parameter int BLANK_CYC  = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output seg7_t                   seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [IW-1:0]           dig_idx,
  output logic                    frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW:0]   BLANK_W  = (PW+1)'(BLANK_CYC);

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    full;

  logic                    term;
  logic                    at_wrap;
  logic                    accept;
  logic                    in_blank;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur;
  logic                    cur_blank;
  seg7_t                   seg_next;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    cur_dp;
`endif

  assign term     = (pre == PRE_LAST);
  assign at_wrap  = term && (idx == IDX_LAST);
  assign in_blank = ({1'b0, pre} < BLANK_W);

  // Never ready on the wrap slot so accept and transfer cannot collide
  assign load_ready = ~full & ~at_wrap;
  assign accept     = load_valid & load_ready;
  assign dig_idx    = idx;

  // A digit blanks when it and all digits above it are zero
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (active[4*k +: 4] == 4'h0);
      lz[k]    = blank_lz & zero_run & (k != 0);
    end
  end

  always_comb begin
    cur       = '0;
    cur_blank = 1'b0;
    onehot    = '0;
`ifdef SEG7_DP_EN
    cur_dp    = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur       = active[4*k +: 4];
        cur_blank = lz[k];
        onehot[k] = 1'b1;
`ifdef SEG7_DP_EN
        cur_dp    = active_dp[k];
`endif
      end
    end
  end

  seg7_decode u_dec (
    .nibble (cur),
    .blank  (cur_blank),
    .seg    (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      full       <= 1'b0;
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
`ifdef SEG7_DP_EN
      active_dp  <= '0;
      shadow_dp  <= '0;
      dp         <= 1'b0;
`endif
    end else begin
      if (ena) begin
        if (term) begin
          pre <= '0;
          idx <= at_wrap ? '0 : idx + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
        frame_done <= at_wrap;
        dig_sel    <= in_blank ? '0 : onehot;
        seg        <= seg_next;
`ifdef SEG7_DP_EN
        dp         <= cur_dp & ~in_blank;
`endif
      end else begin
        frame_done <= 1'b0;
        dig_sel    <= '0;
        seg        <= '0;
`ifdef SEG7_DP_EN
        dp         <= 1'b0;
`endif
      end
      if (ena && at_wrap && full) begin
        active    <= shadow;
        full      <= 1'b0;
`ifdef SEG7_DP_EN
        active_dp <= shadow_dp;
`endif
      end else if (accept) begin
        shadow    <= load_data;
        full      <= 1'b1;
`ifdef SEG7_DP_EN
        shadow_dp <= dp_mask;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver.
// Runs NUM_DIGITS=2, PRESCALE=4, BLANK_CYC=1.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic [0:0] dig_idx;
  logic       frame_done;
`ifdef SEG7_DP_EN
  logic [1:0] dp_mask = 2'b00;
  logic       dp;
`endif

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS (2),
    .PRESCALE   (4),
    .BLANK_CYC  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
`ifdef SEG7_DP_EN
    .dp_mask    (dp_mask),
    .dp         (dp),
`endif
    .seg        (seg),
    .dig_sel    (dig_sel),
    .dig_idx    (dig_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_sel(input int k);
    if (k % 4 == 0) return 2'b00;
    return (k < 4) ? 2'b01 : 2'b10;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b0; load_valid = 1'b0;
    load_data = 8'h00; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg !== 7'h00) begin
      errors++; $display("FAIL rst_seg got %h exp 00", seg);
    end
    checks++;
    if (dig_sel !== 2'b00) begin
      errors++; $display("FAIL rst_sel got %b exp 00", dig_sel);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", load_ready);
    end
    checks++;
    if (dig_idx !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_idx_fd got %b/%b exp 0/0", dig_idx, frame_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (seg !== 7'h00 || dig_sel !== 2'b00) begin
        errors++; $display("FAIL idle_out got %h/%b exp 00/00", seg, dig_sel);
      end
    end
  endtask

  task automatic test_scan;
    load_valid = 1'b1; load_data = 8'h23;
    tick;
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL scan_ready got %b exp 0", load_ready);
    end
    ena = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k) || seg !== 7'h3F) begin
        errors++;
        $display("FAIL scan_f1 k=%0d got %b/%h exp %b/3f", k, dig_sel, seg, exp_sel(k));
      end
      checks++;
      if (frame_done !== (k == 7) || dig_idx !== 1'((k >= 3) && (k < 7))) begin
        errors++;
        $display("FAIL scan_fd k=%0d got fd=%b idx=%b", k, frame_done, dig_idx);
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k) || seg !== ((k < 4) ? 7'h4F : 7'h5B)) begin
        errors++;
        $display("FAIL scan_f2 k=%0d got %b/%h exp %b/%h", k, dig_sel, seg,
                 exp_sel(k), (k < 4) ? 7'h4F : 7'h5B);
      end
      checks++;
      if (frame_done !== (k == 7)) begin
        errors++; $display("FAIL scan_fd2 k=%0d got %b", k, frame_done);
      end
    end
  endtask

  task automatic test_lz;
    blank_lz = 1'b1;
    load_valid = 1'b1; load_data = 8'h05;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k) || seg !== ((k < 4) ? 7'h6D : 7'h00)) begin
        errors++;
        $display("FAIL lz_05 k=%0d got %b/%h exp %b/%h", k, dig_sel, seg,
                 exp_sel(k), (k < 4) ? 7'h6D : 7'h00);
      end
    end
    load_valid = 1'b1; load_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (seg !== ((k < 4) ? 7'h3F : 7'h00)) begin
        errors++;
        $display("FAIL lz_00 k=%0d got %h exp %h", k, seg, (k < 4) ? 7'h3F : 7'h00);
      end
    end
  endtask

  task automatic test_hold;
    blank_lz = 1'b0;
    load_valid = 1'b1; load_data = 8'hAF;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (load_ready !== (k == 7)) begin
        errors++; $display("FAIL hold_ready k=%0d got %b exp %b", k, load_ready, k == 7);
      end
      if (k == 7) load_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k) || seg !== ((k < 4) ? 7'h71 : 7'h77)) begin
        errors++;
        $display("FAIL hold_show k=%0d got %b/%h exp %b/%h", k, dig_sel, seg,
                 exp_sel(k), (k < 4) ? 7'h71 : 7'h77);
      end
      checks++;
      if (load_ready !== (k != 6)) begin
        errors++; $display("FAIL hold_once k=%0d got %b exp %b", k, load_ready, k != 6);
      end
    end
  endtask

  task automatic test_ena;
    tick;
    tick;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (dig_sel !== 2'b00 || seg !== 7'h00 || dig_idx !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL ena_off i=%0d got %b/%h/%b/%b", i, dig_sel, seg, dig_idx, frame_done);
      end
    end
    ena = 1'b1;
    for (int k = 2; k < 8; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k) || seg !== ((k < 4) ? 7'h71 : 7'h77)
          || frame_done !== (k == 7)) begin
        errors++;
        $display("FAIL ena_resume k=%0d got %b/%h/%b exp %b", k, dig_sel, seg,
                 frame_done, exp_sel(k));
      end
    end
  endtask

  task automatic test_reset_mid;
    load_valid = 1'b1; load_data = 8'h12;
    tick;
    load_valid = 1'b0;
    tick;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full got %b exp 0", load_ready);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (seg !== 7'h00 || dig_sel !== 2'b00 || frame_done !== 1'b0 || dig_idx !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out got %h/%b/%b/%b", seg, dig_sel, frame_done, dig_idx);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_ready got %b exp 1", load_ready);
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick;
      checks++;
      if (dig_sel !== exp_sel(k % 8) || seg !== 7'h3F) begin
        errors++;
        $display("FAIL mid_after k=%0d got %b/%h exp %b/3f", k, dig_sel, seg, exp_sel(k % 8));
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_lz;
    test_hold;
    test_ena;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
